// File: rtl/serial_twos_comp_mc_if.sv
// Framing, data and result signals shared between a serial source and the
// multi-lane two's-complement unit.
interface serial_twos_comp_mc_if #(
  parameter int NUM_CH = 4
);
  logic              start;
  logic              in_valid;
  logic [1:0]        mode;
  logic [NUM_CH-1:0] x;
  logic [NUM_CH-1:0] z;
  logic              out_valid;
  logic              out_last;
  logic [NUM_CH-1:0] ovf;

  modport master (
    output start, in_valid, mode, x,
    input  z, out_valid, out_last, ovf
  );

  modport slave (
    input  start, in_valid, mode, x,
    output z, out_valid, out_last, ovf
  );
endinterface

// File: rtl/serial_twos_comp_mc.sv
// Multi-lane bit-serial unit: buffers one LSB-first word per lane, then
// re-emits it as pass, negate or absolute value with per-lane overflow.
module serial_twos_comp_mc #(
  parameter int WORD_W = 8,
  parameter int NUM_CH = 4
) (
  input logic                   clk,
  input logic                   rst,
  serial_twos_comp_mc_if.slave  bus
);
  localparam int IW = $clog2(WORD_W);
  localparam int CW = IW + 1;
  localparam logic [WORD_W-1:0] MIN_WORD = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic {IN_IDLE,  IN_COLLECT} inState_e;
  typedef enum logic {OUT_IDLE, OUT_EMIT}   outState_e;

  inState_e  inState_q,  inState_d;
  outState_e outState_q, outState_d;

  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [1:0]                      mode_q, mode_d;
  logic [NUM_CH-1:0][WORD_W-1:0]   wordBuf_q, wordBuf_d;
  logic                            load;

  logic [CW-1:0]                   ecnt_q, ecnt_d;
  logic [NUM_CH-1:0][WORD_W-1:0]   sreg_q, sreg_d;
  logic [NUM_CH-1:0]               neg_q, neg_d;
  logic [NUM_CH-1:0]               seen_q, seen_d;
  logic [NUM_CH-1:0]               isMin_q, isMin_d;

  logic [NUM_CH-1:0]               z_q, z_d;
  logic                            outValid_q, outValid_d;
  logic                            outLast_q, outLast_d;
  logic [NUM_CH-1:0]               ovf_q, ovf_d;

  // A start with valid data always restarts at bit 0, even mid-word.
  always_comb begin
    inState_d = inState_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    wordBuf_d = wordBuf_q;
    load      = 1'b0;
    if (bus.in_valid) begin
      if (bus.start) begin
        inState_d = IN_COLLECT;
        mode_d    = bus.mode;
        cnt_d     = CW'(1);
        for (int i = 0; i < NUM_CH; i++) wordBuf_d[i][0] = bus.x[i];
      end else if (inState_q == IN_COLLECT) begin
        for (int i = 0; i < NUM_CH; i++) wordBuf_d[i][cnt_q[IW-1:0]] = bus.x[i];
        if (cnt_q == CW'(WORD_W - 1)) begin
          load      = 1'b1;
          cnt_d     = '0;
          inState_d = IN_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // Copy bits up to and including the first 1, invert the rest when negating.
  always_comb begin
    outState_d = outState_q;
    ecnt_d     = ecnt_q;
    sreg_d     = sreg_q;
    neg_d      = neg_q;
    seen_d     = seen_q;
    isMin_d    = isMin_q;
    z_d        = '0;
    outValid_d = 1'b0;
    outLast_d  = 1'b0;
    ovf_d      = '0;
    if (outState_q == OUT_EMIT) begin
      outValid_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        z_d[i]    = sreg_q[i][0] ^ (neg_q[i] & seen_q[i]);
        seen_d[i] = seen_q[i] | sreg_q[i][0];
        sreg_d[i] = sreg_q[i] >> 1;
      end
      if (ecnt_q == CW'(WORD_W - 1)) begin
        outLast_d  = 1'b1;
        ovf_d      = neg_q & isMin_q;
        outState_d = OUT_IDLE;
        ecnt_d     = '0;
      end else begin
        ecnt_d = ecnt_q + CW'(1);
      end
    end
    if (load) begin
      outState_d = OUT_EMIT;
      ecnt_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sreg_d[i]  = wordBuf_d[i];
        neg_d[i]   = (mode_q == 2'b01) | ((mode_q == 2'b10) & wordBuf_d[i][WORD_W-1]);
        seen_d[i]  = 1'b0;
        isMin_d[i] = (wordBuf_d[i] == MIN_WORD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inState_q  <= IN_IDLE;
      outState_q <= OUT_IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      wordBuf_q  <= '0;
      ecnt_q     <= '0;
      sreg_q     <= '0;
      neg_q      <= '0;
      seen_q     <= '0;
      isMin_q    <= '0;
      z_q        <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      inState_q  <= inState_d;
      outState_q <= outState_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      wordBuf_q  <= wordBuf_d;
      ecnt_q     <= ecnt_d;
      sreg_q     <= sreg_d;
      neg_q      <= neg_d;
      seen_q     <= seen_d;
      isMin_q    <= isMin_d;
      z_q        <= z_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.z         = z_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_last  = outLast_q;
  assign bus.ovf       = ovf_q;
endmodule
